// File: rtl/button_pkg.sv
// button_pkg: channel count and bit indices shared by the button conditioner.
package button_pkg;
    localparam int BTN_COUNT   = 6;
    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LEFT    = 2;
    localparam int BTN_RIGHT   = 3;
    localparam int BTN_PAUSE   = 4;
    localparam int BTN_RESTART = 5;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF synchroniser, tick-qualified debounce and rising-edge pulse for one button.
module debounce_channel #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_press
);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);
    logic [1:0] sync_q;
    logic level_q, level_d, prev_q, press_q, diff;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        diff    = sync_q[1] != level_q;
        level_d = (i_tick && diff && cnt_q == LAST) ? sync_q[1] : level_q;
        cnt_d   = !i_tick ? cnt_q : (!diff || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end
    assign o_level = level_q;
    assign o_press = press_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect six player buttons.
// Define BUTTON_PAUSE_TOGGLE_EN to turn the pause button into a latched toggle.
module button_conditioner
    import button_pkg::*;
#(
    parameter int PRESCALE       = 25000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_COUNT-1:0] i_btn_raw,
    output logic                 o_up,
    output logic                 o_down,
    output logic                 o_left,
    output logic                 o_right,
    output logic                 o_restart,
    output logic                 o_pause,
    output logic [BTN_COUNT-1:0] o_press
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    logic [PW-1:0] presc_q, presc_d;
    logic tick;
    logic [BTN_COUNT-1:0] level;
    always_comb begin
        tick    = presc_q == PMAX;
        presc_d = tick ? '0 : presc_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end
    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_ch
        debounce_channel #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (i_btn_raw[i]),
            .i_tick (tick),
            .o_level(level[i]),
            .o_press(o_press[i])
        );
    end
    assign o_up      = level[BTN_UP];
    assign o_down    = level[BTN_DOWN];
    assign o_left    = level[BTN_LEFT];
    assign o_right   = level[BTN_RIGHT];
    assign o_restart = level[BTN_RESTART];
`ifdef BUTTON_PAUSE_TOGGLE_EN
    logic pause_q, pause_d;
    // A restart press overrides a simultaneous pause press.
    always_comb pause_d = o_press[BTN_RESTART] ? 1'b0 : pause_q ^ o_press[BTN_PAUSE];
    always_ff @(posedge clk) begin
        if (rst) pause_q <= 1'b0;
        else     pause_q <= pause_d;
    end
    assign o_pause = pause_q;
`else
    assign o_pause = level[BTN_PAUSE];
`endif
endmodule
